// File: rtl/shifter_iter.sv
// shifter_iter: iterative 16-bit shift/rotate unit.
// Stage amounts 8, 4, 2, 1 are applied on successive clocks (one count bit
// per cycle). Latency is a constant four stage cycles after the accept edge.
// The result is registered on out, and done pulses for one cycle when it
// is written.
module shifter_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] in,
  input  logic [3:0]  cnt,
  input  logic [1:0]  op,
  output logic [15:0] out,
  output logic        busy,
  output logic        done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t      state;
  logic [15:0] work;
  logic [15:0] nxt;
  logic [3:0]  cnt_q;
  logic [1:0]  op_q;
  logic [1:0]  k;

  // One power-of-two stage: amount 2^sk, op as encoded on the op port.
  function automatic logic [15:0] apply_stage(input logic [15:0] v,
                                              input logic [1:0]  sk,
                                              input logic [1:0]  sop);
    logic [15:0] rl, sl, rr, sr;
    case (sk)
      2'd3: begin
        rl = {v[7:0], v[15:8]};
        sl = {v[7:0], 8'h00};
        rr = {v[7:0], v[15:8]};
        sr = {8'h00, v[15:8]};
      end
      2'd2: begin
        rl = {v[11:0], v[15:12]};
        sl = {v[11:0], 4'h0};
        rr = {v[3:0], v[15:4]};
        sr = {4'h0, v[15:4]};
      end
      2'd1: begin
        rl = {v[13:0], v[15:14]};
        sl = {v[13:0], 2'b00};
        rr = {v[1:0], v[15:2]};
        sr = {2'b00, v[15:2]};
      end
      default: begin
        rl = {v[14:0], v[15]};
        sl = {v[14:0], 1'b0};
        rr = {v[0], v[15:1]};
        sr = {1'b0, v[15:1]};
      end
    endcase
    case (sop)
      2'b00:   return rl;
      2'b01:   return sl;
      2'b10:   return rr;
      default: return sr;
    endcase
  endfunction

  // Next working value: apply the current stage only if its count bit is set.
  always_comb begin
    nxt = work;
    if (cnt_q[k]) nxt = apply_stage(work, k, op_q);
  end

  // Busy tracks the SHIFT state directly; the control FSM is the only source.
  always_comb begin
    busy = (state == SHIFT);
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      work  <= '0;
      cnt_q <= '0;
      op_q  <= '0;
      k     <= '0;
      out   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work  <= in;
            cnt_q <= cnt;
            op_q  <= op;
            k     <= 2'd3;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          work <= nxt;
          k    <= k - 2'd1;
          if (k == 2'd0) begin
            out   <= nxt;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
